// File: rtl/rob_commit_if.sv
// rob_commit_if: shared types and the rename/execute/retire bus of the reorder buffer.
//   types_pkg     : DEPTH, PREG_W and the rename_data record (pc, pd_new, pd_old, rob_tag)
//   rob_commit_if : dispatch (valid_in, data_in, ready_in),
//                   completion (cmp_valid, cmp_tag, cmp_mispredict),
//                   retire (free_en, free_preg, mispredict, commit_valid, commit_pc) and tag_err
//   master drives dispatch/completion; slave is the reorder buffer.
package types_pkg;
   localparam int DEPTH  = 16;
   localparam int PREG_W = 7;
   typedef struct packed {
      logic [31:0]       pc;
      logic [PREG_W-1:0] pd_new;
      logic [PREG_W-1:0] pd_old;
      logic [3:0]        rob_tag;
   } rename_data;
endpackage

interface rob_commit_if;
   import types_pkg::*;
   logic              valid_in;
   rename_data        data_in;
   logic              ready_in;
   logic              cmp_valid;
   logic [3:0]        cmp_tag;
   logic              cmp_mispredict;
   logic              free_en;
   logic [PREG_W-1:0] free_preg;
   logic              mispredict;
   logic              commit_valid;
   logic [31:0]       commit_pc;
   logic              tag_err;
   modport master (
      output valid_in, data_in, cmp_valid, cmp_tag, cmp_mispredict,
      input  ready_in, free_en, free_preg, mispredict, commit_valid, commit_pc, tag_err
   );
   modport slave (
      input  valid_in, data_in, cmp_valid, cmp_tag, cmp_mispredict,
      output ready_in, free_en, free_preg, mispredict, commit_valid, commit_pc, tag_err
   );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer; in-order dispatch, out-of-order completion, in-order retire with flush.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rob_commit_if.slave (dispatch, completion, retire/free/flush outputs, sticky tag_err)
module rob_commit
   import types_pkg::*;
(
   input logic         clk,
   input logic         reset,
   rob_commit_if.slave bus
);
   logic [DEPTH-1:0]  valid, done, mispred;
   logic [31:0]       pc_q     [DEPTH];
   logic [PREG_W-1:0] pd_new_q [DEPTH];
   logic [PREG_W-1:0] pd_old_q [DEPTH];
   logic [3:0]        head, tail;
   logic [4:0]        count;
   logic              retire, flush, dispatch, cmp_hit, frees;
   // ready looks only at registered state, so a retire this cycle never frees a slot early
   assign bus.ready_in = (count != 5'(DEPTH)) && !bus.mispredict;
   always_comb begin
      retire   = valid[head] && done[head];
      flush    = retire && mispred[head];
      frees    = retire && (pd_new_q[head] != '0);
      // a dispatch racing a flush is dropped; rename replays it after the pulse
      dispatch = bus.valid_in && bus.ready_in && !flush;
      cmp_hit  = bus.cmp_valid && valid[bus.cmp_tag] && !(dispatch && bus.cmp_tag == tail);
   end
   always_ff @(posedge clk)
      if (dispatch) begin
         pc_q[tail]     <= bus.data_in.pc;
         pd_new_q[tail] <= bus.data_in.pd_new;
         pd_old_q[tail] <= bus.data_in.pd_old;
      end
   always_ff @(posedge clk) begin
      if (reset) begin
         valid            <= '0;
         done             <= '0;
         mispred          <= '0;
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         bus.tag_err      <= 1'b0;
         bus.free_en      <= 1'b0;
         bus.free_preg    <= '0;
         bus.mispredict   <= 1'b0;
         bus.commit_valid <= 1'b0;
         bus.commit_pc    <= '0;
      end else begin
         bus.commit_valid <= retire;
         bus.commit_pc    <= retire ? pc_q[head] : '0;
         bus.free_en      <= frees;
         bus.free_preg    <= frees ? pd_old_q[head] : '0;
         bus.mispredict   <= flush;
         if (cmp_hit) begin
            done[bus.cmp_tag]    <= 1'b1;
            mispred[bus.cmp_tag] <= bus.cmp_mispredict;
         end
         if (dispatch) begin
            valid[tail]   <= 1'b1;
            done[tail]    <= 1'b0;
            mispred[tail] <= 1'b0;
            tail          <= tail + 4'd1;
            if (bus.data_in.rob_tag != tail) bus.tag_err <= 1'b1;
         end
         if (retire) begin
            valid[head] <= 1'b0;
            head        <= head + 4'd1;
         end
         // squashed entries are just invalidated; rename restores their pd_new from its checkpoint
         if (flush) begin
            valid <= '0;
            tail  <= head + 4'd1;
            count <= '0;
         end else
            count <= count + 5'(dispatch) - 5'(retire);
      end
   end
endmodule
